muldiv_ctrl: RTL

Multi-cycle multiply/divide controller for the MIPS pipeline, serving MULT, MULTU, DIV, DIVU, MFHI and MFLO. It accepts an operation issued from decode, runs an iterative shift-add multiplier or a restoring divider, and writes the 64-bit result into the architectural HI/LO registers. It also drives the interlock that stalls decode when an MFHI/MFLO, or a second mult/div, arrives while a computation is still in flight.

---
 rtl/muldiv_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and decode interlock.
// Shift-add multiplier and restoring divider share one 65-bit working register.
module muldiv_ctrl #(
    parameter int unsigned ITER_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_hilo,
    input  logic        sel_hi,
    output logic [31:0] hilo_out,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam int unsigned N    = 32 / ITER_PER_CYCLE;
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       m_q, m_d;
    logic [32:0]       acc_hi_q, acc_hi_d;
    logic [31:0]       acc_lo_q, acc_lo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;

    logic              is_div, is_signed, a_neg, b_neg;
    logic [31:0]       a_mag, b_mag;
    logic [32:0]       step_hi, rem, sum;
    logic [31:0]       step_lo;
    logic [63:0]       prod, prod_fix;
    logic [31:0]       quo_fix, rem_fix, res_hi, res_lo;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign a_neg     = is_signed & a_q[31];
    assign b_neg     = is_signed & b_q[31];
    assign a_mag     = a_neg ? -a_q : a_q;
    assign b_mag     = b_neg ? -b_q : b_q;

    // ITER_PER_CYCLE unrolled steps; divide shifts left into the remainder,
    // multiply adds the multiplicand into the high half and shifts right.
    always_comb begin
        step_hi = acc_hi_q;
        step_lo = acc_lo_q;
        rem     = '0;
        sum     = '0;
        for (int unsigned i = 0; i < ITER_PER_CYCLE; i++) begin
            if (is_div) begin
                rem     = {step_hi[31:0], step_lo[31]};
                step_lo = {step_lo[30:0], 1'b0};
                if (rem >= {1'b0, m_q}) begin
                    rem        = rem - {1'b0, m_q};
                    step_lo[0] = 1'b1;
                end
                step_hi = rem;
            end else begin
                sum     = step_hi + (step_lo[0] ? {1'b0, m_q} : 33'd0);
                step_lo = {sum[0], step_lo[31:1]};
                step_hi = {1'b0, sum[32:1]};
            end
        end
    end

    assign prod     = {acc_hi_q[31:0], acc_lo_q};
    assign prod_fix = (a_neg ^ b_neg) ? -prod : prod;
    assign quo_fix  = (a_neg ^ b_neg) ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = a_neg ? -acc_hi_q[31:0] : acc_hi_q[31:0];

    // Divide by zero bypasses sign fixing so LO stays all-ones and HI is the raw dividend.
    always_comb begin
        res_hi = prod_fix[63:32];
        res_lo = prod_fix[31:0];
        if (is_div) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPrep;
                    op_d    = op;
                    a_d     = rs_data;
                    b_d     = rt_data;
                end
            end
            StPrep: begin
                acc_hi_d = '0;
                acc_lo_d = is_div ? a_mag : b_mag;
                m_d      = is_div ? b_mag : a_mag;
                cnt_d    = CntW'(N - 1);
                state_d  = StRun;
            end
            StRun: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StFix: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign stall    = (rd_hilo | start) & busy;
    assign done     = done_q;
    assign hilo_out = sel_hi ? hi_q : lo_q;

endmodule
